conv_mac_sequencer: RTL and testbench
=====================================

CONV_MAC_SEQUENCER -- requirements
Module: conv_mac_sequencer

Interface
REQ-001 Parameter DW, 16: signed width of activations, weights, bias and outputs.
REQ-002 Parameter ACC_W, 40: signed accumulator width, at least 2*DW+8.
REQ-003 Parameter POF, 8: output channels computed in parallel.
REQ-004 Parameter POX, 8: output pixels computed in parallel.
REQ-005 Parameter MAX_K, 7: maximum kernel size; KW = $clog2(MAX_K+1).
REQ-006 Parameter AW, 16: read-address width.
REQ-007 clk  in  1  Single clock, rising edge.
REQ-008 rst_n  in  1  Reset, synchronous and active-low.
REQ-009 start  in  1  Start request; accepted only in IDLE.
REQ-010 cfg_nif  in  8  Input-channel count; sampled at start accept.
REQ-011 cfg_nkx, cfg_nky  in  KW each  Kernel width and height; sampled at start accept.
REQ-012 cfg_shift  in  5  Arithmetic right shift applied to the accumulator before output.
REQ-013 cfg_relu  in  1  1 clamps negative results to 0.
REQ-014 rd_en  out  1  Read strobe to the activation and weight buffers.
REQ-015 rd_addr  out  AW  Read address, ni*MAX_K*MAX_K + ky*MAX_K + kx.
REQ-016 act_data  in  POX*DW  POX activations, valid exactly 1 cycle after rd_en.
REQ-017 wt_data  in  POF*DW  POF weights, valid exactly 1 cycle after rd_en.
REQ-018 bias  in  POF*DW  Per-channel bias; sampled in the FINAL state.
REQ-019 busy  out  1  High in every state other than IDLE.
REQ-020 out_valid  out  1  Output tile valid.
REQ-021 out_ready  in  1  Downstream accept.
REQ-022 out_data  out  POF*POX*DW  Output tile; lane index = of*POX + ox.
REQ-023 done  out  1  Single-cycle pulse on the cycle of the output handshake.

Function
REQ-024 States and transitions:
- IDLE -> CLEAR on start.
- CLEAR (zero all accumulators) -> RUN.
- RUN -> DRAIN after the last address is issued.
- DRAIN -> FINAL.
- FINAL -> OUTPUT.
- OUTPUT -> IDLE on out_valid && out_ready.
REQ-025 RUN issues N = nif*nky*nkx reads, one per cycle, with rd_en high.
- Loop order: ni outermost, then ky, then kx innermost.
- Counters wrap to 0 at the configured limit.
REQ-026 Accumulation: the cycle after each read, acc[of][ox] += act[ox]*wt[of], using full 2*DW signed products sign-extended to ACC_W.
REQ-027 FINAL computes, per lane, r = (acc + sign-extended bias) >>> cfg_shift.
- ReLU is applied if enabled.
- The result saturates to the DW signed range [-2^(DW-1), 2^(DW-1)-1].
- The result is registered into out_data.
REQ-028 Latency: out_valid first rises N+3 cycles after the start-accept edge.
REQ-029 out_valid and out_data remain stable while out_ready is low; there is no timeout.
REQ-030 If cfg_nif, cfg_nkx or cfg_nky is 0, the block skips RUN (CLEAR -> DRAIN), issues no reads, and outputs the saturated, shifted bias.
REQ-031 A cfg_nkx or cfg_nky value above MAX_K is clamped to MAX_K.
REQ-032 start while busy is ignored, and cfg inputs may change during busy without effect.
REQ-033 start asserted on the same cycle as an output handshake is ignored; a new start is accepted from IDLE on the following cycle.

Reset
REQ-034 When rst_n is low at a clock edge, the block SHALL:
- enter IDLE;
- clear all counters, accumulators and out_data to 0;
- drive rd_en, busy, out_valid and done to 0.
REQ-035 Reset asserted mid-RUN or mid-OUTPUT aborts the tile; no done pulse follows.

Structure
REQ-036 Shared package conv_pkg holds:
- the state enum (IDLE, CLEAR, RUN, DRAIN, FINAL, OUTPUT);
- default parameter constants;
- the saturate/shift helper function.
REQ-037 Sub-module conv_mac_lane: one signed multiply-accumulate register with clear and enable, instantiated POF*POX times from a generate loop.

Verification
REQ-038 Config POF=2, POX=2, nif=1, nk=1, all act=3, wt=4, bias=5, shift 0 -> all four lanes = 17; out_valid at cycle 4 after start.
REQ-039 Config nif=2, nkx=nky=3, act=1, wt=1, bias=0 -> lanes = 18; exactly 18 rd_en cycles; rd_addr for ni=1, ky=0, kx=0 is 49.
REQ-040 DW=16, act=200, wt=200, N=1 -> product 40000 saturates to 32767; with wt=-200 and cfg_relu=1 -> 0.
REQ-041 out_ready held low 5 cycles -> out_data unchanged, done only on the accept cycle, start during the wait ignored.
REQ-042 rst_n low during RUN cycle 3 -> all outputs 0 on the next cycle; a fresh start then produces the correct result.
REQ-043 cfg_nky=0, bias=-7, shift 0 -> no rd_en, out_data = -7 per channel, out_valid at cycle 3.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, defaults and output post-processing for the conv MAC sequencer.
// Holds the FSM state encoding and the shift/relu/saturate helper.
package conv_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_POF   = 8;
  localparam int DEF_POX   = 8;
  localparam int DEF_MAX_K = 7;
  localparam int DEF_AW    = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    FINAL,
    OUTPUT
  } state_t;

  // Wide signed in, result clamped to the dw-bit signed range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] v,
    input logic        [4:0]  sh,
    input logic               relu,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = v >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu && r < 0) r = '0;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Buffer read bus and output tile stream of the conv MAC sequencer.
// master = sequencer side, slave = buffers / downstream consumer.
interface conv_mac_sequencer_if
  import conv_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int POF = DEF_POF,
  parameter int POX = DEF_POX,
  parameter int AW  = DEF_AW
) ();

  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [POX*DW-1:0]       act_data;
  logic [POF*DW-1:0]       wt_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [POF*POX*DW-1:0]   out_data;

  modport master (
    output rd_en, rd_addr, out_valid, out_data,
    input  act_data, wt_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data,
    output act_data, wt_data, out_ready
  );

endinterface

// File: rtl/conv_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
// Full-width product is sign-extended into the accumulator.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DW-1:0]           a,
  input  logic [DW-1:0]           w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = $signed(a) * $signed(w);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Convolution tile sequencer: walks ni/ky/kx, feeds POF x POX MAC lanes,
// then adds bias, shifts, optionally clamps negatives and saturates.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int POF   = DEF_POF,
  parameter int POX   = DEF_POX,
  parameter int MAX_K = DEF_MAX_K,
  parameter int AW    = DEF_AW,
  localparam int KW   = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        cfg_nif,
  input  logic [KW-1:0]     cfg_nkx,
  input  logic [KW-1:0]     cfg_nky,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [POF*DW-1:0] bias,
  output logic              busy,
  output logic              done,
  conv_mac_sequencer_if.master bus
);

  localparam logic [AW-1:0] MK  = AW'(MAX_K);
  localparam logic [AW-1:0] MK2 = AW'(MAX_K * MAX_K);
  localparam int            NL  = POF * POX;

  state_t            state;
  logic [7:0]        nif;
  logic [7:0]        ni;
  logic [7:0]        ni_n;
  logic [KW-1:0]     nkx;
  logic [KW-1:0]     nky;
  logic [KW-1:0]     kx;
  logic [KW-1:0]     ky;
  logic [KW-1:0]     kx_n;
  logic [KW-1:0]     ky_n;
  logic [4:0]        shift;
  logic              relu;
  logic              nz;
  logic              last;
  logic              rd_en_d;
  logic              clr;
  logic [NL*DW-1:0]  res;

  logic signed [ACC_W-1:0] acc [NL];

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    return (k > KW'(MAX_K)) ? KW'(MAX_K) : k;
  endfunction

  function automatic logic [AW-1:0] addr_of(
    input logic [7:0]    n,
    input logic [KW-1:0] y,
    input logic [KW-1:0] x
  );
    return AW'(n) * MK2 + AW'(y) * MK + AW'(x);
  endfunction

  assign clr  = (state == CLEAR);
  assign done = bus.out_valid & bus.out_ready;
  assign last = (kx == nkx - 1'b1) &&
                (ky == nky - 1'b1) &&
                (ni == nif - 8'd1);

  // kx innermost, ni outermost
  always_comb begin
    kx_n = kx + 1'b1;
    ky_n = ky;
    ni_n = ni;
    if (kx == nkx - 1'b1) begin
      kx_n = '0;
      ky_n = ky + 1'b1;
      if (ky == nky - 1'b1) begin
        ky_n = '0;
        ni_n = ni + 8'd1;
      end
    end
  end

  always_comb begin
    res = '0;
    for (int f = 0; f < POF; f++) begin
      for (int x = 0; x < POX; x++) begin
        res[(f*POX+x)*DW +: DW] = DW'(sat_shift(
          64'(acc[f*POX+x]) + 64'($signed(bias[f*DW +: DW])),
          shift, relu, DW));
      end
    end
  end

  // read data lands one cycle after rd_en
  always_ff @(posedge clk) begin
    if (!rst_n) rd_en_d <= 1'b0;
    else        rd_en_d <= bus.rd_en;
  end

  for (genvar f = 0; f < POF; f++) begin : g_of
    for (genvar x = 0; x < POX; x++) begin : g_ox
      conv_mac_lane #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (rd_en_d),
        .a     (bus.act_data[x*DW +: DW]),
        .w     (bus.wt_data[f*DW +: DW]),
        .acc   (acc[f*POX+x])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      nif           <= '0;
      nkx           <= '0;
      nky           <= '0;
      ni            <= '0;
      ky            <= '0;
      kx            <= '0;
      shift         <= '0;
      relu          <= 1'b0;
      nz            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            busy  <= 1'b1;
            nif   <= cfg_nif;
            nkx   <= clamp_k(cfg_nkx);
            nky   <= clamp_k(cfg_nky);
            shift <= cfg_shift;
            relu  <= cfg_relu;
            nz    <= (cfg_nif != '0) &&
                     (cfg_nkx != '0) &&
                     (cfg_nky != '0);
          end
        end
        CLEAR: begin
          ni          <= '0;
          ky          <= '0;
          kx          <= '0;
          bus.rd_addr <= '0;
          if (nz) begin
            state     <= RUN;
            bus.rd_en <= 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        RUN: begin
          if (last) begin
            state     <= DRAIN;
            bus.rd_en <= 1'b0;
            ni        <= '0;
            ky        <= '0;
            kx        <= '0;
          end else begin
            ni          <= ni_n;
            ky          <= ky_n;
            kx          <= kx_n;
            bus.rd_addr <= addr_of(ni_n, ky_n, kx_n);
          end
        end
        DRAIN: state <= FINAL;
        FINAL: begin
          state         <= OUTPUT;
          bus.out_valid <= 1'b1;
          bus.out_data  <= res;
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed + randomized bench for conv_mac_sequencer (POF=POX=2).
// Expected tiles come from a direct sum-of-products model over a RAM image.
module tb_conv_mac_sequencer;
  import conv_pkg::*;

  localparam int DW    = 16;
  localparam int ACC_W = 40;
  localparam int POF   = 2;
  localparam int POX   = 2;
  localparam int MAX_K = 7;
  localparam int AW    = 16;
  localparam int KW    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        cfg_nif = '0;
  logic [KW-1:0]     cfg_nkx = '0;
  logic [KW-1:0]     cfg_nky = '0;
  logic [4:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic [POF*DW-1:0] bias = '0;
  logic              busy;
  logic              done;

  conv_mac_sequencer_if #(.DW(DW), .POF(POF), .POX(POX), .AW(AW)) bus ();

  conv_mac_sequencer #(
    .DW(DW), .ACC_W(ACC_W), .POF(POF), .POX(POX), .MAX_K(MAX_K), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_nif(cfg_nif), .cfg_nkx(cfg_nkx), .cfg_nky(cfg_nky),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .bias(bias),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [POX*DW-1:0] act_mem [512];
  logic [POF*DW-1:0] wt_mem  [512];
  logic [AW-1:0]     rd_log  [4096];
  int                rd_cnt = 0;

  // synchronous buffer: data valid the cycle after rd_en
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.act_data <= act_mem[bus.rd_addr[8:0]];
      bus.wt_data  <= wt_mem[bus.rd_addr[8:0]];
      rd_log[rd_cnt % 4096] <= bus.rd_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] w);
    for (int i = 0; i < 512; i++) begin
      act_mem[i] = {POX{a}};
      wt_mem[i]  = {POF{w}};
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) begin
      act_mem[i] = {POX*DW/16{16'($urandom)}};
      wt_mem[i]  = {POF*DW/16{16'($urandom)}};
      for (int x = 0; x < POX; x++) act_mem[i][x*DW +: DW] = DW'($urandom);
      for (int f = 0; f < POF; f++) wt_mem[i][f*DW +: DW] = DW'($urandom);
    end
  endtask

  function automatic int kclamp(input int k);
    return (k > MAX_K) ? MAX_K : k;
  endfunction

  function automatic logic [63:0] model(
    input int nif, input int nkx, input int nky,
    input logic [4:0] sh, input logic relu, input logic [POF*DW-1:0] b);
    logic [63:0] o;
    longint s, av, wv, hi, lo;
    int a;
    o  = '0;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    for (int f = 0; f < POF; f++) begin
      for (int x = 0; x < POX; x++) begin
        s = 0;
        for (int n = 0; n < nif; n++)
          for (int y = 0; y < kclamp(nky); y++)
            for (int k = 0; k < kclamp(nkx); k++) begin
              a  = n * MAX_K * MAX_K + y * MAX_K + k;
              av = longint'($signed(act_mem[a][x*DW +: DW]));
              wv = longint'($signed(wt_mem[a][f*DW +: DW]));
              s  = s + av * wv;
            end
        s = s + longint'($signed(b[f*DW +: DW]));
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        o[(f*POX+x)*DW +: DW] = s[DW-1:0];
      end
    end
    return o;
  endfunction

  logic [63:0] last_out;
  int          last_base;

  task automatic run_tile(input int nif, input int nkx, input int nky,
                          input logic [4:0] sh, input logic relu,
                          input logic [POF*DW-1:0] b, input int hold,
                          input bit overlap, input string tag);
    int n, c;
    logic [63:0] exp;
    n   = nif * kclamp(nkx) * kclamp(nky);
    exp = model(nif, nkx, nky, sh, relu, b);
    last_base = rd_cnt;
    cfg_nif = 8'(nif);
    cfg_nkx = KW'(nkx);
    cfg_nky = KW'(nky);
    cfg_shift = sh;
    cfg_relu = relu;
    bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cfg_nif = 8'($urandom);
    cfg_nkx = KW'($urandom);
    cfg_nky = KW'($urandom);
    cfg_shift = 5'($urandom);
    cfg_relu = 1'($urandom);
    c = 0;
    while (!bus.out_valid && c < n + 20) begin
      tick();
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(n + 3));
    check({tag, "_rdcount"}, 64'(rd_cnt - last_base), 64'(n));
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, bus.out_data, exp);
      check({tag, "_hold_done"}, 64'(done), 64'd0);
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
    end
    check({tag, "_data"}, bus.out_data, exp);
    last_out = bus.out_data;
    bus.out_ready = 1'b1;
    if (overlap) start = 1'b1;
    #1;
    check({tag, "_done"}, 64'(done), 64'd1);
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_low"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    if (overlap) begin
      cfg_nif = 8'(nif);
      cfg_nkx = KW'(nkx);
      cfg_nky = KW'(nky);
      cfg_shift = sh;
      cfg_relu = relu;
      tick();
      start = 1'b0;
      check({tag, "_restart"}, 64'(busy), 64'd1);
      c = 0;
      while (!bus.out_valid && c < n + 20) begin
        tick();
        c++;
      end
      check({tag, "_re_data"}, bus.out_data, exp);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m7;
    m7 = -16'sd7;
    bus.out_ready = 1'b0;
    fill(16'd0, 16'd0);
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", bus.out_data, 64'd0);
    rst_n = 1'b1;
    tick();

    fill(16'd3, 16'd4);
    run_tile(1, 1, 1, 5'd0, 1'b0, {POF{16'd5}}, 0, 1'b0, "basic");
    check("basic_const", last_out, 64'h0011_0011_0011_0011);

    fill(16'd1, 16'd1);
    run_tile(2, 3, 3, 5'd0, 1'b0, '0, 0, 1'b0, "k3");
    check("k3_const", last_out, 64'h0012_0012_0012_0012);
    check("k3_addr49", 64'(rd_log[(last_base + 9) % 4096]), 64'd49);

    fill(16'd200, 16'd200);
    run_tile(1, 1, 1, 5'd0, 1'b0, '0, 0, 1'b0, "satpos");
    check("satpos_const", last_out, 64'h7fff_7fff_7fff_7fff);
    fill(16'd200, -16'sd200);
    run_tile(1, 1, 1, 5'd0, 1'b1, '0, 0, 1'b0, "relu");
    check("relu_const", last_out, 64'd0);
    run_tile(1, 1, 1, 5'd0, 1'b0, '0, 0, 1'b0, "satneg");
    check("satneg_const", last_out, 64'h8000_8000_8000_8000);

    fill_rand();
    run_tile(2, 2, 2, 5'd3, 1'b0, {16'h0123, 16'hff00}, 5, 1'b1, "stall");

    run_tile(3, 4, 0, 5'd0, 1'b0, {m7, m7}, 0, 1'b0, "nky0");
    check("nky0_const", last_out, {m7, m7, m7, m7});

    fill(16'd1, 16'd1);
    cfg_nif = 8'd2;
    cfg_nkx = 3'd3;
    cfg_nky = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("mid_rst_addr", 64'(bus.rd_addr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", bus.out_data, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("mid_rst_no_done", 64'(bus.out_valid), 64'd0);
    run_tile(2, 3, 3, 5'd1, 1'b0, {16'd2, 16'd4}, 0, 1'b0, "post_rst");

    for (int t = 0; t < 12; t++) begin
      fill_rand();
      run_tile(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 5'($urandom_range(0, 24)),
               1'($urandom_range(0, 1)), POF*DW'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
